// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU pipeline control blocks: hazard FSM states,
// default parameters, bubble encodings and the packed control-output bundle.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int CNT_W_DEF        = 16;

  // Encodings the pipeline registers load when flushed.
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [7:0]  BUBBLE_CTRL = 8'h00;

  typedef struct packed {
    logic pc_write;
    logic pc_src_branch;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
    logic halted;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, pc_src_branch: 1'b0, if_id_write: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, pipe_freeze: 1'b0, halted: 1'b0
  };

  localparam hz_ctrl_t CTRL_RESET = '{
    pc_write: 1'b0, pc_src_branch: 1'b0, if_id_write: 1'b0,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, pipe_freeze: 1'b0, halted: 1'b0
  };

  localparam hz_ctrl_t CTRL_HALT = '{
    pc_write: 1'b0, pc_src_branch: 1'b0, if_id_write: 1'b0,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, pipe_freeze: 1'b1, halted: 1'b1
  };

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clear wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: turns hazard indications into PC/IF/ID/EX
// enables, flushes and freeze, and runs the HLT drain sequence.
module hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dataDep,
  input  logic             branch_taken,
  input  logic             halt_id,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             pc_src_branch,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hz_state_t     state_q, state_d;
  logic          ld_stalled_q, ld_stalled_d;
  logic [DW-1:0] drain_q, drain_d;
  hz_ctrl_t      ctrl;
  logic          stall_inc;
  logic          flush_inc;

  always_comb begin
    ctrl         = CTRL_RUN;
    state_d      = state_q;
    ld_stalled_d = ld_stalled_q;
    drain_d      = drain_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_busy) begin
          // EX is frozen; keep the stall history while the dependency persists.
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          ctrl.pipe_freeze = 1'b1;
          if (!dataDep) begin
            ld_stalled_d = 1'b0;
          end
        end else if (branch_taken) begin
          ctrl.pc_src_branch = 1'b1;
          ctrl.if_id_flush   = 1'b1;
          ctrl.id_ex_flush   = 1'b1;
          flush_inc          = 1'b1;
          ld_stalled_d       = 1'b0;
        end else if (dataDep && !ld_stalled_q) begin
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          ctrl.id_ex_flush = 1'b1;
          stall_inc        = 1'b1;
          ld_stalled_d     = 1'b1;
        end else if (dataDep) begin
          ld_stalled_d = 1'b0;
        end else begin
          ld_stalled_d = 1'b0;
          if (halt_id) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_flush = 1'b1;
            drain_d          = DW'(DRAIN_CYCLES - 1);
            state_d          = DRAIN;
          end
        end
      end

      DRAIN: begin
        ctrl.pc_write    = 1'b0;
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
        ld_stalled_d     = 1'b0;
        if (mem_busy) begin
          ctrl.pipe_freeze = 1'b1;
        end else if (drain_q == '0) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      HALTED: begin
        ctrl         = CTRL_HALT;
        ld_stalled_d = 1'b0;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      ctrl      = CTRL_RESET;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      ld_stalled_q <= 1'b0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      ld_stalled_q <= ld_stalled_d;
      drain_q      <= drain_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clear_i (rst),
    .inc_i   (stall_inc),
    .cnt_o   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .clear_i (rst),
    .inc_i   (flush_inc),
    .cnt_o   (flush_cnt)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_src_branch = ctrl.pc_src_branch;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign pipe_freeze   = ctrl.pipe_freeze;
  assign halted        = ctrl.halted;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second 8-bit-counter instance shares the
// stimulus so counter saturation is reached within a short run.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst, dataDep, branch_taken, halt_id, mem_busy;

  logic        pc_write, pc_src_branch, if_id_write, if_id_flush;
  logic        id_ex_flush, pipe_freeze, halted;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_pc_src_branch, s_if_id_write, s_if_id_flush;
  logic        s_id_ex_flush, s_pipe_freeze, s_halted;
  logic [7:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // {pc_write, pc_src_branch, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, halted}
  localparam logic [6:0] C_RUN   = 7'b1010000;
  localparam logic [6:0] C_RST   = 7'b0001100;
  localparam logic [6:0] C_BUSY  = 7'b0000010;
  localparam logic [6:0] C_BR    = 7'b1111100;
  localparam logic [6:0] C_STALL = 7'b0000100;
  localparam logic [6:0] C_HLT   = 7'b0011000;
  localparam logic [6:0] C_DRN   = 7'b0011100;
  localparam logic [6:0] C_DRNB  = 7'b0011110;
  localparam logic [6:0] C_HALT  = 7'b0000011;

  logic [6:0] ctl;
  assign ctl = {pc_write, pc_src_branch, if_id_write, if_id_flush,
                id_ex_flush, pipe_freeze, halted};

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) u_dut (
    .clk (clk), .rst (rst), .dataDep (dataDep), .branch_taken (branch_taken),
    .halt_id (halt_id), .mem_busy (mem_busy), .pc_write (pc_write),
    .pc_src_branch (pc_src_branch), .if_id_write (if_id_write),
    .if_id_flush (if_id_flush), .id_ex_flush (id_ex_flush),
    .pipe_freeze (pipe_freeze), .halted (halted),
    .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
  );

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(8)) u_dut_sat (
    .clk (clk), .rst (rst), .dataDep (dataDep), .branch_taken (branch_taken),
    .halt_id (halt_id), .mem_busy (mem_busy), .pc_write (s_pc_write),
    .pc_src_branch (s_pc_src_branch), .if_id_write (s_if_id_write),
    .if_id_flush (s_if_id_flush), .id_ex_flush (s_id_ex_flush),
    .pipe_freeze (s_pipe_freeze), .halted (s_halted),
    .stall_cnt (s_stall_cnt), .flush_cnt (s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic d, input logic b, input logic h, input logic m);
    rst = 1'b0; dataDep = d; branch_taken = b; halt_id = h; mem_busy = m;
  endtask

  // Apply one cycle of inputs, check the combinational controls, advance.
  task automatic cyc(input string tag, input logic d, input logic b,
                     input logic h, input logic m, input logic [6:0] exp);
    drv(d, b, h, m);
    #1;
    chk(tag, 32'(ctl), 32'(exp));
    $display("step %-14s dep=%0b br=%0b hlt=%0b busy=%0b ctl=%07b stall=%0d flush=%0d",
             tag, d, b, h, m, ctl, stall_cnt, flush_cnt);
    tick();
  endtask

  task automatic cnts(input string tag, input int st, input int fl);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'(st));
    chk({tag, "_flush"}, 32'(flush_cnt), 32'(fl));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; dataDep = 1'b0; branch_taken = 1'b0; halt_id = 1'b0; mem_busy = 1'b0;
    #1;
    chk({tag, "_rst_ctl"}, 32'(ctl), 32'(C_RST));
    tick();
    rst = 1'b0;
    cnts({tag, "_rst"}, 0, 0);
    chk({tag, "_rst_sstall"}, 32'(s_stall_cnt), 32'd0);
    chk({tag, "_rst_sflush"}, 32'(s_flush_cnt), 32'd0);
  endtask

  initial begin
    do_reset("init");
    cyc("idle", 0, 0, 0, 0, C_RUN);

    // Load-use: one bubble, then the dependency is satisfied.
    cyc("ld_use1", 1, 0, 0, 0, C_STALL);
    cnts("ld_use1", 1, 0);
    cyc("ld_use2", 1, 0, 0, 0, C_RUN);
    cnts("ld_use2", 1, 0);
    cyc("ld_idle", 0, 0, 0, 0, C_RUN);

    // Branch beats a simultaneous dependency.
    do_reset("brdep");
    cyc("br_dep", 1, 1, 0, 0, C_BR);
    cnts("br_dep", 0, 1);
    cyc("dep_after_br", 1, 0, 0, 0, C_STALL);
    cnts("dep_after_br", 1, 1);

    // Memory busy freezes a pending branch for four cycles.
    do_reset("memfrz");
    for (int i = 0; i < 4; i++) begin
      cyc("busy_br", 0, 1, 0, 1, C_BUSY);
      cnts("busy_br", 0, 0);
    end
    cyc("br_release", 0, 1, 0, 0, C_BR);
    cnts("br_release", 0, 1);
    cyc("busy_dep", 1, 0, 0, 1, C_BUSY);
    cnts("busy_dep", 0, 1);
    cyc("dep_release", 1, 0, 0, 0, C_STALL);
    cnts("dep_release", 1, 1);

    // Halt: three drain cycles, then sticky HALTED.
    do_reset("halt");
    cyc("hlt", 0, 0, 1, 0, C_HLT);
    for (int i = 0; i < 3; i++) cyc("drain", 0, 0, 0, 0, C_DRN);
    for (int i = 0; i < 22; i++) begin
      cyc("halted", (i % 3) == 0, (i % 2) == 0, (i % 5) == 0, 1'b0, C_HALT);
    end
    cnts("halted", 0, 0);
    do_reset("from_halt");
    cyc("idle_after_halt", 0, 0, 0, 0, C_RUN);

    // Halt with two busy cycles in DRAIN; branch/dep in DRAIN ignored.
    do_reset("drnbusy");
    cyc("hlt_b", 0, 0, 1, 0, C_HLT);
    cyc("drain_b1", 0, 1, 0, 0, C_DRN);
    cyc("drain_busy1", 0, 0, 0, 1, C_DRNB);
    cyc("drain_busy2", 0, 1, 0, 1, C_DRNB);
    cyc("drain_b2", 1, 0, 0, 0, C_DRN);
    cyc("drain_b3", 0, 0, 0, 0, C_DRN);
    cyc("halted_b", 0, 0, 0, 0, C_HALT);
    cnts("drnbusy", 0, 0);

    // Reset mid-DRAIN with nonzero counters, then mid-stall.
    do_reset("middrn");
    cyc("pre_stall", 1, 0, 0, 0, C_STALL);
    cyc("pre_br", 0, 1, 0, 0, C_BR);
    cnts("pre", 1, 1);
    cyc("hlt_m", 0, 0, 1, 0, C_HLT);
    cyc("drain_m", 0, 0, 0, 0, C_DRN);
    do_reset("in_drain");
    cyc("run_after_rst", 0, 0, 0, 0, C_RUN);
    cyc("stall_m", 1, 0, 0, 0, C_STALL);
    do_reset("in_stall");
    cyc("stall_again", 1, 0, 0, 0, C_STALL);
    cnts("stall_again", 1, 0);

    // Saturation: continuous dataDep gives one stall every other cycle.
    do_reset("sat");
    drv(1, 0, 0, 0);
    for (int i = 0; i < 510; i++) tick();
    chk("sat255_big", 32'(stall_cnt), 32'd255);
    chk("sat255_small", 32'(s_stall_cnt), 32'hFF);
    for (int i = 0; i < 90; i++) tick();
    chk("sat300_big", 32'(stall_cnt), 32'd300);
    chk("sat300_small", 32'(s_stall_cnt), 32'hFF);
    $display("step sat_stall      big=%0d small=%0d", stall_cnt, s_stall_cnt);
    drv(0, 1, 0, 0);
    for (int i = 0; i < 300; i++) tick();
    chk("satfl_big", 32'(flush_cnt), 32'd300);
    chk("satfl_small", 32'(s_flush_cnt), 32'hFF);
    chk("satfl_small_stall", 32'(s_stall_cnt), 32'hFF);
    $display("step sat_flush      big=%0d small=%0d", flush_cnt, s_flush_cnt);
    do_reset("sat_clear");
    cyc("final_idle", 0, 0, 0, 0, C_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
